// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between fetch control and pc_sequencer.
//   master: drives start/step/stall/redirect/halt requests, observes PC state.
//   slave : the sequencer itself.
//   Signals: i_start, i_step_mode, i_step, i_stall, i_branch_taken, i_branch_addr,
//            i_jump, i_jump_addr, i_halt (requests); o_pc, o_next_pc, o_flush,
//            o_halted, o_cycles (status); o_misalign only with PC_ALIGN_CHECK_EN.
interface pc_sequencer_if #(parameter int NBITS = 32);
    logic             i_start;
    logic             i_step_mode;
    logic             i_step;
    logic             i_stall;
    logic             i_branch_taken;
    logic [NBITS-1:0] i_branch_addr;
    logic             i_jump;
    logic [NBITS-1:0] i_jump_addr;
    logic             i_halt;
    logic [NBITS-1:0] o_pc;
    logic [NBITS-1:0] o_next_pc;
    logic             o_flush;
    logic             o_halted;
    logic [31:0]      o_cycles;
`ifdef PC_ALIGN_CHECK_EN
    logic             o_misalign;
    modport master(output i_start, i_step_mode, i_step, i_stall, i_branch_taken,
                   i_branch_addr, i_jump, i_jump_addr, i_halt,
                   input o_pc, o_next_pc, o_flush, o_halted, o_cycles, o_misalign);
    modport slave(input i_start, i_step_mode, i_step, i_stall, i_branch_taken,
                  i_branch_addr, i_jump, i_jump_addr, i_halt,
                  output o_pc, o_next_pc, o_flush, o_halted, o_cycles, o_misalign);
`else
    modport master(output i_start, i_step_mode, i_step, i_stall, i_branch_taken,
                   i_branch_addr, i_jump, i_jump_addr, i_halt,
                   input o_pc, o_next_pc, o_flush, o_halted, o_cycles);
    modport slave(input i_start, i_step_mode, i_step, i_stall, i_branch_taken,
                  i_branch_addr, i_jump, i_jump_addr, i_halt,
                  output o_pc, o_next_pc, o_flush, o_halted, o_cycles);
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with run / single-step / halt sequencing.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset (PC <= RESET_PC, state IDLE)
//   bus     : pc_sequencer_if.slave -- start/step/stall/redirect/halt requests in,
//             o_pc, o_next_pc (comb pc+INC), o_flush (registered, one cycle),
//             o_halted, o_cycles (count of PC updates) out.
//   Optional: define PC_ALIGN_CHECK_EN to trap word-misaligned jump/branch targets
//             (target not loaded, enter HALTED, sticky o_misalign).
module pc_sequencer #(
    parameter int               NBITS    = 32,
    parameter logic [NBITS-1:0] RESET_PC = '0,
    parameter int               INC      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    pc_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, HALTED} state_t;

    state_t           state;
    logic [NBITS-1:0] pc;
    logic             flush;
    logic             halted;
    logic [31:0]      cycles;
    logic             update;
    logic             redirect;
    logic [NBITS-1:0] target;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign;
`endif

    // A mode change out of RUN or STEP_WAIT takes the cycle without moving the PC.
    assign update   = (state == RUN && !bus.i_step_mode) ||
                      (state == STEP_WAIT && bus.i_step_mode && bus.i_step);
    assign redirect = bus.i_jump || bus.i_branch_taken;
    assign target   = bus.i_jump ? bus.i_jump_addr : bus.i_branch_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            flush  <= 1'b0;
            halted <= 1'b0;
            cycles <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
            flush <= 1'b0;
            case (state)
                IDLE:      if (bus.i_start) state <= bus.i_step_mode ? STEP_WAIT : RUN;
                RUN:       if (bus.i_step_mode) state <= STEP_WAIT;
                STEP_WAIT: if (!bus.i_step_mode) state <= RUN;
                default:   ;
            endcase
            // Stalled cycles drop any redirect; the requester re-asserts it.
            if (update && !bus.i_stall) begin
                // Halt and misalign traps leave the PC untouched, so they are not counted.
                if (bus.i_halt) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
`ifdef PC_ALIGN_CHECK_EN
                else if (redirect && target[1:0] != 2'b00) begin
                    state    <= HALTED;
                    halted   <= 1'b1;
                    misalign <= 1'b1;
                end
`endif
                else begin
                    pc     <= redirect ? target : pc + NBITS'(INC);
                    flush  <= redirect;
                    cycles <= cycles + 32'd1;
                end
            end
        end
    end

    assign bus.o_pc      = pc;
    assign bus.o_next_pc = pc + NBITS'(INC);
    assign bus.o_flush   = flush;
    assign bus.o_halted  = halted;
    assign bus.o_cycles  = cycles;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.o_misalign = misalign;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, directed corner sequences and random run against a reference model.
module tb_pc_sequencer;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.NBITS(32)) bus();
    pc_sequencer_if #(.NBITS(32)) bus2();

    pc_sequencer #(.NBITS(32), .RESET_PC(32'h0), .INC(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
    pc_sequencer #(.NBITS(32), .RESET_PC(32'hFFFF_FFF8), .INC(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 running, 2 waiting for a step, 3 halted.
    int          m_mode;
    logic [31:0] m_pc, m_cyc;
    logic        m_flush, m_halt, m_mis;

    typedef struct {
        logic        start, mode, step, stall, br;
        logic [31:0] baddr;
        logic        jmp;
        logic [31:0] jaddr;
        logic        halt;
        logic [31:0] pc;
        logic        flush;
        logic [31:0] cyc;
    } vec_t;
    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        bus.i_start = 0; bus.i_step_mode = 0; bus.i_step = 0; bus.i_stall = 0;
        bus.i_branch_taken = 0; bus.i_branch_addr = 0; bus.i_jump = 0;
        bus.i_jump_addr = 0; bus.i_halt = 0;
    endtask

    // Called 1 time unit after a rising edge; reset is applied and released between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_pc", bus.o_pc, 32'h0);
        check("rst_flush", 32'(bus.o_flush), 0);
        check("rst_halted", 32'(bus.o_halted), 0);
        check("rst_cycles", bus.o_cycles, 0);
        check("rst_pc2", bus2.o_pc, 32'hFFFF_FFF8);
`ifdef PC_ALIGN_CHECK_EN
        check("rst_misalign", 32'(bus.o_misalign), 0);
`endif
        rst_n = 1'b1;
        m_mode = 0; m_pc = 0; m_cyc = 0; m_flush = 0; m_halt = 0; m_mis = 0;
    endtask

    task automatic model_step();
        bit          adv;
        bit          redir;
        logic [31:0] tgt;
        adv = (m_mode == 1 && !bus.i_step_mode) || (m_mode == 2 && bus.i_step_mode && bus.i_step);
        m_flush = 0;
        if (m_mode == 0 && bus.i_start) m_mode = bus.i_step_mode ? 2 : 1;
        else if (m_mode == 1 && bus.i_step_mode) m_mode = 2;
        else if (m_mode == 2 && !bus.i_step_mode) m_mode = 1;
        if (adv && !bus.i_stall) begin
            redir = bus.i_jump || bus.i_branch_taken;
            tgt = bus.i_jump ? bus.i_jump_addr : bus.i_branch_addr;
            if (bus.i_halt) begin
                m_mode = 3; m_halt = 1;
            end else if (ALIGN && redir && (tgt % 4) != 0) begin
                m_mode = 3; m_halt = 1; m_mis = 1;
            end else begin
                m_pc = redir ? tgt : m_pc + 32'd4;
                m_flush = redir;
                m_cyc = m_cyc + 1;
            end
        end
    endtask

    task automatic tick_model();
        model_step();
        @(posedge clk); #1;
        check("pc", bus.o_pc, m_pc);
        check("next_pc", bus.o_next_pc, m_pc + 32'd4);
        check("flush", 32'(bus.o_flush), 32'(m_flush));
        check("halted", 32'(bus.o_halted), 32'(m_halt));
        check("cycles", bus.o_cycles, m_cyc);
`ifdef PC_ALIGN_CHECK_EN
        check("misalign", 32'(bus.o_misalign), 32'(m_mis));
`endif
    endtask

    initial begin
        int hc;
        clr();
        bus2.i_start = 0; bus2.i_step_mode = 0; bus2.i_step = 0; bus2.i_stall = 0;
        bus2.i_branch_taken = 0; bus2.i_branch_addr = 0; bus2.i_jump = 0;
        bus2.i_jump_addr = 0; bus2.i_halt = 0;

        //          st md sp sl br baddr   jm jaddr   hl  pc      fl cyc
        vt[0]  = '{1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h4,   0, 1};
        vt[2]  = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h8,   0, 2};
        vt[3]  = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'hC,   0, 3};
        vt[4]  = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h10,  0, 4};
        vt[5]  = '{0, 0, 0, 0, 1, 32'h40,  0, 32'h0,  0, 32'h40,  1, 5};
        vt[6]  = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h44,  0, 6};
        vt[7]  = '{0, 0, 0, 0, 1, 32'h40,  1, 32'h80, 0, 32'h80,  1, 7};
        vt[8]  = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h84,  0, 8};
        vt[9]  = '{0, 0, 0, 0, 1, 32'h20,  0, 32'h0,  0, 32'h20,  1, 9};
        vt[10] = '{0, 0, 0, 1, 1, 32'h100, 0, 32'h0,  0, 32'h20,  0, 9};
        vt[11] = '{0, 0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h24,  0, 10};
        vt[12] = '{0, 0, 0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h24,  0, 10};

        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            bus.i_start = vt[i].start; bus.i_step_mode = vt[i].mode; bus.i_step = vt[i].step;
            bus.i_stall = vt[i].stall; bus.i_branch_taken = vt[i].br;
            bus.i_branch_addr = vt[i].baddr; bus.i_jump = vt[i].jmp;
            bus.i_jump_addr = vt[i].jaddr; bus.i_halt = vt[i].halt;
            @(posedge clk); #1;
            check($sformatf("vec%0d_pc", i), bus.o_pc, vt[i].pc);
            check($sformatf("vec%0d_flush", i), 32'(bus.o_flush), 32'(vt[i].flush));
            check($sformatf("vec%0d_cycles", i), bus.o_cycles, vt[i].cyc);
        end

        // Mid-run asynchronous reset, then single-step sequence ending in halt.
        clr();
        do_reset();
        bus.i_step_mode = 1; bus.i_start = 1;
        tick_model();
        bus.i_start = 0;
        repeat (3) tick_model();
        check("step_idle_pc", bus.o_pc, 32'h0);
        bus.i_step = 1; tick_model();
        check("step1_pc", bus.o_pc, 32'h4);
        bus.i_step = 0; tick_model();
        bus.i_step = 1; tick_model();
        check("step2_pc", bus.o_pc, 32'h8);
        bus.i_halt = 1; tick_model();
        check("halt_flag", 32'(bus.o_halted), 1);
        for (int i = 0; i < 100; i++) begin
            bus.i_step = 1'($urandom); bus.i_step_mode = 1'($urandom);
            bus.i_jump = 1'($urandom); bus.i_jump_addr = $urandom & ~32'h3;
            bus.i_start = 1'($urandom); bus.i_halt = 0;
            tick_model();
        end
        check("halt_frozen_pc", bus.o_pc, 32'h8);
        check("halt_frozen_cycles", bus.o_cycles, 32'd2);

        // Misaligned jump target.
        clr();
        do_reset();
        bus.i_start = 1; tick_model();
        bus.i_start = 0; tick_model();
        bus.i_jump = 1; bus.i_jump_addr = 32'h42; tick_model();
        bus.i_jump = 0;
        check("misjump_pc", bus.o_pc, ALIGN ? 32'h4 : 32'h42);
        check("misjump_halted", 32'(bus.o_halted), ALIGN ? 32'd1 : 32'd0);
        tick_model();

        // Randomized run against the model.
        clr();
        do_reset();
        hc = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.i_start = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) bus.i_step_mode = ~bus.i_step_mode;
            bus.i_step = ($urandom_range(2) == 0);
            bus.i_stall = ($urandom_range(4) == 0);
            bus.i_branch_taken = ($urandom_range(3) == 0);
            bus.i_jump = ($urandom_range(5) == 0);
            bus.i_halt = ($urandom_range(63) == 0);
            bus.i_branch_addr = ($urandom_range(7) == 0) ? $urandom : ($urandom & ~32'h3);
            bus.i_jump_addr = ($urandom_range(7) == 0) ? $urandom : ($urandom & ~32'h3);
            tick_model();
            hc = (m_mode == 3) ? hc + 1 : 0;
            if (hc > 10) begin
                do_reset();
                hc = 0;
            end
        end

        // Sequential wrap on the second instance.
        bus2.i_start = 1;
        @(posedge clk); #1;
        check("wrap_start_pc", bus2.o_pc, 32'hFFFF_FFF8);
        bus2.i_start = 0;
        @(posedge clk); #1;
        check("wrap_pc1", bus2.o_pc, 32'hFFFF_FFFC);
        check("wrap_next_pc", bus2.o_next_pc, 32'h0);
        @(posedge clk); #1;
        check("wrap_pc2", bus2.o_pc, 32'h0);
        check("wrap_cycles", bus2.o_cycles, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
